// File: rtl/gen_timer_if.sv
// gen_timer_if: control/status bundle between the APB register block and the
// timer core.
//   master : register block side. It drives the controls and reads the count and status.
//   slave  : timer core side.
// Controls : en, up_dn, clk_sel, load, load_val, auto_reload, cmp_val, flag_clr
// Status   : cnt, count_en, ovf, udf, cmp_match, ovf_flag, udf_flag
interface gen_timer_if #(
  parameter int CNT_W = 16,
  parameter int SEL_W = 3
);
  logic             en;
  logic             up_dn;
  logic [SEL_W-1:0] clk_sel;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             auto_reload;
  logic [CNT_W-1:0] cmp_val;
  logic [1:0]       flag_clr;

  logic [CNT_W-1:0] cnt;
  logic             count_en;
  logic             ovf;
  logic             udf;
  logic             cmp_match;
  logic             ovf_flag;
  logic             udf_flag;

  modport master (
    output en, up_dn, clk_sel, load, load_val, auto_reload, cmp_val, flag_clr,
    input  cnt, count_en, ovf, udf, cmp_match, ovf_flag, udf_flag
  );

  modport slave (
    input  en, up_dn, clk_sel, load, load_val, auto_reload, cmp_val, flag_clr,
    output cnt, count_en, ovf, udf, cmp_match, ovf_flag, udf_flag
  );
endinterface

// File: rtl/gen_timer_core.sv
// gen_timer_core: parametrised timer counter with a programmable prescaler,
// optional auto-reload, a compare match, and sticky overflow/underflow status.
//   pclk     : system clock. All state updates on the rising edge.
//   preset_n : synchronous active-low reset.
//   bus      : gen_timer_if slave port. It carries the controls from the register
//              block and returns cnt, count_en, the event pulses and the sticky flags.
// A counter tick occurs every 2^(clk_sel+1) pclk cycles while en=1.
module gen_timer_core #(
  parameter int CNT_W = 16,
  parameter int SEL_W = 3
) (
  input logic        pclk,
  input logic        preset_n,
  gen_timer_if.slave bus
);
  localparam int               PSC_W   = 2 ** SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_mask;
  logic [SEL_W-1:0] sel_q;
  logic             dir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_q, udf_q, cmp_q;
  logic             ovf_flag_q, udf_flag_q;
  logic             restart;
  logic             tick;
  logic             ovf_evt, udf_evt, cmp_evt;

  // The low clk_sel+1 prescaler bits select the divide ratio.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    psc_mask = '0;
    for (int i = 0; i < PSC_W; i++) begin
      psc_mask[i] = (i <= int'(bus.clk_sel));
    end
  end

  // A change of divide select or direction restarts the period and suppresses
  // the tick in the cycle the change is seen.
  assign restart = (bus.clk_sel != sel_q) || (bus.up_dn != dir_q);
  assign tick    = bus.en && !bus.load && !restart && ((psc & psc_mask) == psc_mask);

  // Next count and wrap detection. A load takes priority over a tick, so a
  // load never produces ovf/udf.
  always_comb begin
    cnt_nxt = cnt_q;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (bus.load) begin
      cnt_nxt = bus.load_val;
    end else if (tick && !bus.up_dn) begin
      if (cnt_q == CNT_MAX) begin
        ovf_evt = 1'b1;
        cnt_nxt = bus.auto_reload ? bus.load_val : '0;
      end else begin
        cnt_nxt = cnt_q + 1'b1;
      end
    end else if (tick) begin
      if (cnt_q == '0) begin
        udf_evt = 1'b1;
        cnt_nxt = bus.auto_reload ? bus.load_val : CNT_MAX;
      end else begin
        cnt_nxt = cnt_q - 1'b1;
      end
    end
    // A match fires only when the count changes (load or tick), never on a hold.
    cmp_evt = (bus.load || tick) && (cnt_nxt == bus.cmp_val);
  end

  always_ff @(posedge pclk) begin
    // NOTE: preset_n is sampled only at the clock edge (synchronous reset), so it is not in the sensitivity list.
    if (!preset_n) begin
      psc        <= '0;
      sel_q      <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      cmp_q      <= 1'b0;
      ovf_flag_q <= 1'b0;
      udf_flag_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments: every register samples the pre-edge values and no evaluation-order races occur.
      sel_q <= bus.clk_sel;
      dir_q <= bus.up_dn;
      if (bus.load || restart) begin
        psc <= '0;
      end else if (bus.en) begin
        psc <= psc + 1'b1;
      end
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_evt;
      udf_q <= udf_evt;
      cmp_q <= cmp_evt;
      // A set takes priority over a clear in the same cycle.
      ovf_flag_q <= ovf_evt | (ovf_flag_q & ~bus.flag_clr[0]);
      udf_flag_q <= udf_evt | (udf_flag_q & ~bus.flag_clr[1]);
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.count_en  = tick;
  assign bus.ovf       = ovf_q;
  assign bus.udf       = udf_q;
  assign bus.cmp_match = cmp_q;
  assign bus.ovf_flag  = ovf_flag_q;
  assign bus.udf_flag  = udf_flag_q;
endmodule

// File: tb/tb_gen_timer_core.sv
// tb_gen_timer_core: scoreboard bench for gen_timer_core with the default sizing
// (CNT_W=16, SEL_W=3). Each scenario pushes the per-cycle expected outputs
// {cnt, count_en, ovf, udf, cmp_match} when it drives the stimulus. It then pops
// one entry per cycle and compares it against the DUT outputs.
module tb_gen_timer_core;
  typedef struct packed {
    logic [15:0] cnt;
    logic        ce;
    logic        ovf;
    logic        udf;
    logic        cmp;
  } obs_t;

  logic pclk = 1'b0;
  logic preset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t sb[$];

  gen_timer_if #(.CNT_W(16), .SEL_W(3)) tif ();

  gen_timer_core #(.CNT_W(16), .SEL_W(3)) dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .bus     (tif.slave)
  );

  always #5 pclk = ~pclk;

  // Advance one edge. Sampling and driving both happen 1 ns after the edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  function automatic obs_t sample();
    sample = {tif.cnt, tif.count_en, tif.ovf, tif.udf, tif.cmp_match};
  endfunction

  // Expected-value generator. It produces n cycles of output starting from
  // count c0. The counter sits ph cycles into a period of div cycles. Wrap
  // values and the event pulses follow the timer's rules. The pulses appear
  // one cycle after the tick that causes them.
  task automatic push_seq(input logic [15:0] c0, input logic dn, input logic ar,
                          input logic [15:0] lv, input logic [15:0] cv,
                          input int div, input int ph, input int n, input logic cmp0);
    logic [15:0] c;
    logic        p_ovf, p_udf, p_cmp;
    obs_t        e;
    c = c0; p_ovf = 1'b0; p_udf = 1'b0; p_cmp = cmp0;
    for (int k = 0; k < n; k++) begin
      e.cnt = c;
      e.ce  = (((k + ph) % div) == div - 1);
      e.ovf = p_ovf;
      e.udf = p_udf;
      e.cmp = p_cmp;
      sb.push_back(e);
      p_ovf = 1'b0; p_udf = 1'b0; p_cmp = 1'b0;
      if (e.ce) begin
        if (!dn) begin
          if (c == 16'hFFFF) begin p_ovf = 1'b1; c = ar ? lv : 16'h0000; end
          else c = c + 16'd1;
        end else begin
          if (c == 16'h0000) begin p_udf = 1'b1; c = ar ? lv : 16'hFFFF; end
          else c = c - 16'd1;
        end
        p_cmp = (c == cv);
      end
    end
  endtask

  // Apply the configuration together with a one-cycle load pulse. On return
  // the bench sits just after the load edge, which is sample k=0.
  task automatic do_load(input logic [15:0] lv, input logic dn, input logic ar,
                         input logic [2:0] sel);
    tif.en = 1'b1; tif.up_dn = dn; tif.auto_reload = ar; tif.clk_sel = sel;
    tif.load_val = lv; tif.load = 1'b1;
    step();
    tif.load = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    obs_t z;
    z = '0;
    preset_n = 1'b0;
    tif.en = 1'b0; tif.up_dn = 1'b0; tif.clk_sel = '0; tif.load = 1'b0;
    tif.load_val = '0; tif.auto_reload = 1'b0; tif.cmp_val = 16'h1234; tif.flag_clr = '0;
    step(); step();
    o = sample();
    n_cmp++;
    if (o !== z) begin
      n_bad++;
      $display("FAIL reset_outputs: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required all 0",
               o.cnt, o.ce, o.ovf, o.udf, o.cmp);
    end
    n_cmp++;
    if ({tif.ovf_flag, tif.udf_flag} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_flags: got ovf_flag/udf_flag=%b%b, required 00", tif.ovf_flag, tif.udf_flag);
    end
    preset_n = 1'b1;
    step();
  endtask

  task automatic test_up_count();
    obs_t o, e;
    int   k;
    do_load(16'h0000, 1'b0, 1'b0, 3'd0);
    push_seq(16'h0000, 1'b0, 1'b0, 16'h0000, 16'h1234, 2, 0, 6, 1'b0);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL up_count k=%0d: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required cnt=%h %b%b%b%b",
                 k, o.cnt, o.ce, o.ovf, o.udf, o.cmp, e.cnt, e.ce, e.ovf, e.udf, e.cmp);
      end
      k++;
      if (sb.size() > 0) step();
    end
  endtask

  task automatic test_down();
    obs_t o, e;
    int   k;
    do_load(16'hFFFF, 1'b1, 1'b0, 3'd1);
    push_seq(16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'h1234, 4, 0, 12, 1'b0);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL down_count k=%0d: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required cnt=%h %b%b%b%b",
                 k, o.cnt, o.ce, o.ovf, o.udf, o.cmp, e.cnt, e.ce, e.ovf, e.udf, e.cmp);
      end
      k++;
      if (sb.size() > 0) step();
    end
  endtask

  task automatic test_ovf_reload();
    obs_t o, e;
    int   k;
    do_load(16'hFFFE, 1'b0, 1'b1, 3'd0);
    push_seq(16'hFFFE, 1'b0, 1'b1, 16'hFFFE, 16'h1234, 2, 0, 8, 1'b0);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL ovf_reload k=%0d: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required cnt=%h %b%b%b%b",
                 k, o.cnt, o.ce, o.ovf, o.udf, o.cmp, e.cnt, e.ce, e.ovf, e.udf, e.cmp);
      end
      k++;
      if (sb.size() > 0) step();
    end
    tif.en = 1'b0;
    step(); step();
    n_cmp++;
    if (tif.ovf_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_flag_sticky: got %b, required 1", tif.ovf_flag);
    end
    tif.flag_clr = 2'b01;
    step();
    tif.flag_clr = 2'b00;
    n_cmp++;
    if (tif.ovf_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_flag_clear: got %b, required 0", tif.ovf_flag);
    end
  endtask

  task automatic test_udf();
    obs_t o, e;
    int   k;
    do_load(16'h0001, 1'b1, 1'b0, 3'd0);
    push_seq(16'h0001, 1'b1, 1'b0, 16'h0001, 16'h1234, 2, 0, 6, 1'b0);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL udf_no_reload k=%0d: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required cnt=%h %b%b%b%b",
                 k, o.cnt, o.ce, o.ovf, o.udf, o.cmp, e.cnt, e.ce, e.ovf, e.udf, e.cmp);
      end
      k++;
      if (sb.size() > 0) step();
    end
    tif.en = 1'b0;
    step();
    n_cmp++;
    if (tif.udf_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL udf_flag_set: got %b, required 1", tif.udf_flag);
    end
    tif.flag_clr = 2'b10;
    step();
    tif.flag_clr = 2'b00;
    n_cmp++;
    if (tif.udf_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL udf_flag_clear: got %b, required 0", tif.udf_flag);
    end
    // An underflow tick and a clear in the same cycle: the set must win.
    do_load(16'h0000, 1'b1, 1'b0, 3'd0);
    step();
    n_cmp++;
    if (tif.count_en !== 1'b1) begin
      n_bad++;
      $display("FAIL udf_tick_strobe: got count_en=%b, required 1", tif.count_en);
    end
    tif.flag_clr = 2'b10;
    step();
    tif.flag_clr = 2'b00;
    tif.en = 1'b0;
    n_cmp++;
    if ({tif.cnt, tif.udf, tif.udf_flag} !== {16'hFFFF, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL udf_set_beats_clear: got cnt=%h udf=%b udf_flag=%b, required cnt=ffff udf=1 udf_flag=1",
               tif.cnt, tif.udf, tif.udf_flag);
    end
  endtask

  task automatic test_compare_restart();
    obs_t o, e;
    int   k;
    tif.cmp_val = 16'h00A0;
    do_load(16'h009E, 1'b0, 1'b0, 3'd0);
    push_seq(16'h009E, 1'b0, 1'b0, 16'h009E, 16'h00A0, 2, 0, 6, 1'b0);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL cmp_count k=%0d: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required cnt=%h %b%b%b%b",
                 k, o.cnt, o.ce, o.ovf, o.udf, o.cmp, e.cnt, e.ce, e.ovf, e.udf, e.cmp);
      end
      k++;
      if (sb.size() > 0) step();
    end
    // Hold at the compare value. No further match may fire.
    tif.en = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back('{cnt: 16'h00A0, ce: 1'b0, ovf: 1'b0, udf: 1'b0, cmp: 1'b0});
    step();
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL cmp_hold k=%0d: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required cnt=%h %b%b%b%b",
                 k, o.cnt, o.ce, o.ovf, o.udf, o.cmp, e.cnt, e.ce, e.ovf, e.udf, e.cmp);
      end
      k++;
      if (sb.size() > 0) step();
    end
    // Resume from the frozen prescaler phase. The prescaler is 5, one cycle into a period.
    tif.en = 1'b1;
    #1;
    push_seq(16'h00A0, 1'b0, 1'b0, 16'h009E, 16'h00A0, 2, 1, 3, 1'b0);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL resume_phase k=%0d: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required cnt=%h %b%b%b%b",
                 k, o.cnt, o.ce, o.ovf, o.udf, o.cmp, e.cnt, e.ce, e.ovf, e.udf, e.cmp);
      end
      k++;
      if (sb.size() > 0) step();
    end
    // The prescaler is 7, which would also tick at the new ratio. The restart must suppress that tick.
    tif.clk_sel = 3'd1;
    #1;
    n_cmp++;
    if (tif.count_en !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_suppress: got count_en=%b, required 0", tif.count_en);
    end
    step();
    push_seq(16'h00A1, 1'b0, 1'b0, 16'h009E, 16'h00A0, 4, 0, 8, 1'b0);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL restart_period k=%0d: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required cnt=%h %b%b%b%b",
                 k, o.cnt, o.ce, o.ovf, o.udf, o.cmp, e.cnt, e.ce, e.ovf, e.udf, e.cmp);
      end
      k++;
      if (sb.size() > 0) step();
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    obs_t z;
    int   k;
    z = '0;
    do_load(16'h0000, 1'b0, 1'b0, 3'd2);
    push_seq(16'h0000, 1'b0, 1'b0, 16'h0000, 16'h00A0, 8, 0, 20, 1'b0);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL div8_count k=%0d: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required cnt=%h %b%b%b%b",
                 k, o.cnt, o.ce, o.ovf, o.udf, o.cmp, e.cnt, e.ce, e.ovf, e.udf, e.cmp);
      end
      k++;
      if (sb.size() > 0) step();
    end
    n_cmp++;
    if (tif.udf_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL udf_flag_before_reset: got %b, required 1", tif.udf_flag);
    end
    preset_n = 1'b0;
    step();
    o = sample();
    n_cmp++;
    if (o !== z) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required all 0",
               o.cnt, o.ce, o.ovf, o.udf, o.cmp);
    end
    n_cmp++;
    if ({tif.ovf_flag, tif.udf_flag} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_mid_flags: got ovf_flag/udf_flag=%b%b, required 00", tif.ovf_flag, tif.udf_flag);
    end
    preset_n = 1'b1;
    // Reset cleared the stored clk_sel, so the first cycle after reset restarts the prescaler.
    step();
    push_seq(16'h0000, 1'b0, 1'b0, 16'h0000, 16'h00A0, 8, 0, 18, 1'b0);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_resume k=%0d: got cnt=%h ce/ovf/udf/cmp=%b%b%b%b, required cnt=%h %b%b%b%b",
                 k, o.cnt, o.ce, o.ovf, o.udf, o.cmp, e.cnt, e.ce, e.ovf, e.udf, e.cmp);
      end
      k++;
      if (sb.size() > 0) step();
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down();
    test_ovf_reload();
    test_udf();
    test_compare_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gen_timer_core.md
# gen_timer_core

Parametrised timer counter core: the next-generation successor of the fixed 8-bit timer counter. It adds a configurable counter width, a programmable clock divider, optional auto-reload, compare match, and sticky overflow/underflow status. It sits behind the APB register block, which drives its control inputs from TCR/TDR-style registers and reads back `cnt` and the status flags. All logic runs on `pclk`.

## Interface
- `CNT_W`, 16: counter width in bits (≥ 2).
- `SEL_W`, 3: width of `clk_sel`. Prescaler width is 2^SEL_W bits.
- `pclk` input 1: system clock; all state updates on the rising edge.
- `preset_n` input 1: reset, synchronous, active-low.
- `en` input 1: count enable. 0 holds both the prescaler and the counter.
- `up_dn` input 1: direction. 0 = up, 1 = down.
- `clk_sel` input SEL_W: divide select. A counter tick occurs every 2^(clk_sel+1) pclk cycles.
- `load` input 1: single-cycle pulse. Loads `load_val` into the counter and clears the prescaler.
- `load_val` input CNT_W: load value, also used as the reload value.
- `auto_reload` input 1: 1 = wrap to `load_val`; 0 = wrap to the natural boundary.
- `cmp_val` input CNT_W: compare value.
- `flag_clr` input 2: bit 0 clears `ovf_flag`, bit 1 clears `udf_flag`.
- `cnt` output CNT_W: current count.
- `count_en` output 1: tick strobe. High in the cycle before `cnt` advances.
- `ovf` output 1: one-cycle pulse on overflow.
- `udf` output 1: one-cycle pulse on underflow.
- `cmp_match` output 1: one-cycle pulse when `cnt` becomes equal to `cmp_val`.
- `ovf_flag` output 1: sticky overflow status.
- `udf_flag` output 1: sticky underflow status.

## Operation
- **Prescaler.** `psc` is 2^SEL_W bits wide. It increments each cycle while `en`=1.
- **Divide ratio.** Let div = 2^(clk_sel+1). `count_en` is combinational: (psc[clk_sel:0] == all ones) && `en` && !`load`.
- **Prescaler restart.**
  - A change of `clk_sel` or `up_dn` (compared against the previous-cycle register) clears `psc`. No tick occurs in that cycle.
  - `load` also clears `psc`.
- **Counter update (priority order).**
  1. Reset.
  2. `load`: `cnt` ← `load_val`.
  3. `count_en` in up mode: `cnt`+1, or the wrap value when `cnt` = 2^CNT_W−1.
  4. `count_en` in down mode: `cnt`−1, or the wrap value when `cnt` = 0.
  5. Otherwise `cnt` holds.
- **Wrap values.**
  - Up, `auto_reload`=0: wrap to 0. Up, `auto_reload`=1: wrap to `load_val`.
  - Down, `auto_reload`=0: wrap to 2^CNT_W−1. Down, `auto_reload`=1: wrap to `load_val`.
- **Event pulses.**
  - `ovf` is registered and high for one cycle after an up-wrap.
  - `udf` is registered and high for one cycle after a down-wrap.
- **Compare match.** `cmp_match` is registered. It is high for one cycle after any tick or load that produces `cnt` == `cmp_val`. It does not fire while `cnt` is merely holding at `cmp_val`.
- **Sticky flags.**
  - `ovf_flag` is set by an overflow event and cleared by `flag_clr[0]`.
  - `udf_flag` is set by an underflow event and cleared by `flag_clr[1]`.
  - If set and clear occur in the same cycle, set wins.
- **Arithmetic.** All arithmetic is modulo 2^CNT_W. Only `clk_sel` values whose ratio fits the prescaler are legal (all values are legal when SEL_W ≤ 3 with the default sizing).

## Timing
- **Reset.** `preset_n`=0 sampled at an edge sets the following to 0: `cnt`, `psc`, `ovf`, `udf`, `cmp_match`, `ovf_flag`, `udf_flag`, and the previous `clk_sel`/`up_dn` registers. `count_en` is therefore 0 after reset.
- **Reset mid-count.** Same result; no pulse is emitted.
- **Load latency.** `load` high at edge E:
  - `cnt` = `load_val` after E.
  - The first tick strobe is in cycle E+div−1, and `cnt` advances at edge E+div. The counter advances every div cycles after that.
- **Disable.** `en`=0 freezes `psc` and `cnt`. Re-enabling resumes from the frozen `psc` phase with no restart.
- **Load plus tick in the same cycle.** Load wins. No `ovf`/`udf` is generated; `cmp_match` is evaluated on `load_val`.
- **Flag clear with no event.** The flag reads 0 in the cycle after the clear.
- **Event pulse latency.** `ovf`, `udf` and `cmp_match` assert in the same cycle that `cnt` shows the new value.

## Test plan
1. **Reset then up count.** Reset; `load`=1 with `load_val`=0; `clk_sel`=0; `up_dn`=0; `en`=1. Required: `cnt` reads 0, then 1 two cycles after load, then 2 two cycles later.
2. **Down from all ones.** `load_val`=16'hFFFF, `up_dn`=1, `clk_sel`=1. Required: `cnt` reads FFFF, FFFE, FFFD at 4-cycle spacing; `count_en` pulses once per 4 cycles.
3. **Up auto-reload overflow.** `load_val`=16'hFFFE, `auto_reload`=1. Required: FFFE → FFFF → FFFE; `ovf` pulses once; `ovf_flag`=1 and stays 1 until `flag_clr[0]`.
4. **Down underflow, no reload.** `load_val`=1, `up_dn`=1, `auto_reload`=0. Required: 1 → 0 → FFFF; `udf` pulses once; set and clear in the same cycle leaves `udf_flag`=1.
5. **Compare and restart.** `cmp_val`=16'h00A0, load 0x009E, count up. Required: `cmp_match` pulses once when `cnt`=00A0 and does not pulse while `en`=0 holds `cnt` at 00A0. Toggling `clk_sel` mid-period restarts the prescaler: the next tick occurs a full new div after the toggle.
6. **Reset mid-count.** Count at `clk_sel`=2 and assert `preset_n`=0 for one edge. Required: all outputs are 0 at the next edge; counting resumes from 0 with full-period spacing.
